// File: rtl/stream_burst_ctrl_if.sv
// Bundle of the stream_burst_ctrl side-band and output-stream signals.
//   last      : per-core "program finished" pulses (into the sequencer)
//   dst_ready : downstream TREADY (into the sequencer)
//   dst_valid : TVALID, dst_last : TLAST
//   stream_v  : read strobe to the core-array result port, stream_i : its index
//   busy      : sequencer has work in flight, overflow : sticky dropped-trigger flag
// master = sequencer side, slave = environment side.
interface stream_burst_ctrl_if #(
    parameter int unsigned CORENUM = 16,
    parameter int unsigned IW      = 3
);
    logic [CORENUM-1:0] last;
    logic               dst_ready;
    logic               dst_valid;
    logic               dst_last;
    logic               stream_v;
    logic [IW-1:0]      stream_i;
    logic               busy;
    logic               overflow;

    modport master (
        input  last, dst_ready,
        output dst_valid, dst_last, stream_v, stream_i, busy, overflow
    );

    modport slave (
        output last, dst_ready,
        input  dst_valid, dst_last, stream_v, stream_i, busy, overflow
    );
endinterface

// File: rtl/stream_burst_ctrl.sv
// Output-stream sequencer between the core array and the AXI4-Stream master.
// Collects per-core completion pulses (ANY or ALL mode), delays each trigger
// through a settle pipe so in-flight core stores land, queues settled triggers
// in a pending counter and replays each one as a BEATS-long indexed read burst
// under dst_ready backpressure.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream_burst_ctrl_if.master (last, dst_ready in; dst_valid,
//              dst_last, stream_v (combinational), stream_i, busy, overflow out)
module stream_burst_ctrl #(
    parameter int unsigned CORENUM    = 16,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned BEATS      = 8,
    parameter int unsigned IW         = $clog2(BEATS),
    parameter int unsigned MODE_ALL   = 0,
    parameter int unsigned PEND_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    stream_burst_ctrl_if.master bus
);

    localparam int unsigned PW       = $clog2(PEND_DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(PEND_DEPTH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    logic [CORENUM-1:0] mask_q, mask_d, mask_or;
    logic               trig;
    logic [SETTLE-1:0]  pipe_q, pipe_d;
    logic               st;
    logic [PW-1:0]      pend_q, pend_d;
    logic               ovf_q, ovf_d;
    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               stream_v_c;
    logic               burst_end_c;
    logic               dst_valid_q, dst_valid_d;
    logic               dst_last_q, dst_last_d;
    logic               busy_q, busy_d;

    // Trigger generation; in ALL mode the bits arriving in the firing cycle
    // are consumed along with the mask.
    always_comb begin
        mask_or = mask_q | bus.last;
        mask_d  = '0;
        trig    = 1'b0;
        if (MODE_ALL != 0) begin
            trig   = &mask_or;
            mask_d = trig ? '0 : mask_or;
        end else begin
            trig   = |bus.last;
        end
    end

    // Settle shift register; stage SETTLE-1 is the settled trigger.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = trig;
        for (int unsigned i = 1; i < SETTLE; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign st          = pipe_q[SETTLE-1];
    assign stream_v_c  = (state_q == S_STREAM) && bus.dst_ready;
    assign burst_end_c = stream_v_c && (idx_q == LAST_IDX);

    // Pending-burst counter; a settled trigger into a full queue is dropped.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        case ({st, burst_end_c})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + PW'(1);
                end
            end
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase
    end

    // Burst FSM: next state, read index and registered stream outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dst_valid_d = dst_valid_q;
        dst_last_d  = dst_last_q;
        busy_d      = (|pipe_q) || (pend_q != '0) || (state_q == S_STREAM);

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (pend_q != '0) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (stream_v_c) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // back-to-back bursts continue without a bubble
                        if (pend_d == '0) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        // Presented beat stays frozen until the sink is ready.
        if (bus.dst_ready) begin
            dst_valid_d = stream_v_c;
            dst_last_d  = burst_end_c;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= '0;
            pipe_q      <= '0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            idx_q       <= '0;
            dst_valid_q <= 1'b0;
            dst_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            pipe_q      <= pipe_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            dst_valid_q <= dst_valid_d;
            dst_last_q  <= dst_last_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dst_valid = dst_valid_q;
    assign bus.dst_last  = dst_last_q;
    assign bus.stream_v  = stream_v_c;
    assign bus.stream_i  = idx_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_stream_burst_ctrl.sv
// Directed bench for stream_burst_ctrl: three instances (ANY mode default,
// ALL mode with 4 cores, ANY mode with a 2-deep queue). A negedge monitor logs
// per-cycle activity of the selected instance relative to reset release.
module tb_stream_burst_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_burst_ctrl_if #(.CORENUM(16), .IW(3)) if_any ();
    stream_burst_ctrl_if #(.CORENUM(4),  .IW(3)) if_all ();
    stream_burst_ctrl_if #(.CORENUM(16), .IW(3)) if_ovf ();

    stream_burst_ctrl u_any (.clk(clk), .rst(rst), .bus(if_any));
    stream_burst_ctrl #(.CORENUM(4), .MODE_ALL(1)) u_all (.clk(clk), .rst(rst), .bus(if_all));
    stream_burst_ctrl #(.PEND_DEPTH(2)) u_ovf (.clk(clk), .rst(rst), .bus(if_ovf));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int base = 0;
    int sel = 0;
    logic mon_clr = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Selected instance's outputs.
    logic       m_sv, m_dv, m_dl, m_rdy, m_busy, m_ovf;
    logic [2:0] m_si;
    always_comb begin
        m_sv = 1'b0; m_dv = 1'b0; m_dl = 1'b0; m_rdy = 1'b0; m_busy = 1'b0;
        m_ovf = 1'b0; m_si = '0;
        case (sel)
            0: begin m_sv = if_any.stream_v; m_dv = if_any.dst_valid; m_dl = if_any.dst_last;
                     m_rdy = if_any.dst_ready; m_busy = if_any.busy; m_ovf = if_any.overflow;
                     m_si = if_any.stream_i; end
            1: begin m_sv = if_all.stream_v; m_dv = if_all.dst_valid; m_dl = if_all.dst_last;
                     m_rdy = if_all.dst_ready; m_busy = if_all.busy; m_ovf = if_all.overflow;
                     m_si = if_all.stream_i; end
            default: begin m_sv = if_ovf.stream_v; m_dv = if_ovf.dst_valid; m_dl = if_ovf.dst_last;
                     m_rdy = if_ovf.dst_ready; m_busy = if_ovf.busy; m_ovf = if_ovf.overflow;
                     m_si = if_ovf.stream_i; end
        endcase
    end

    // Activity log, cycle numbers relative to reset release.
    int sv_cnt, sv_first, sv_lastc, acc_cnt, acc_last_cnt, acc_last_c, dv_first, dv_lastc, busy_lastc;
    logic [2:0] idx_log [0:31];
    always @(negedge clk) begin
        if (mon_clr) begin
            sv_cnt <= 0; sv_first <= -1; sv_lastc <= -1; acc_cnt <= 0; acc_last_cnt <= 0;
            acc_last_c <= -1; dv_first <= -1; dv_lastc <= -1; busy_lastc <= -1;
        end else begin
            if (m_sv) begin
                if (sv_first < 0) sv_first <= cyc - base;
                sv_lastc <= cyc - base;
                if (sv_cnt < 32) idx_log[sv_cnt] <= m_si;
                sv_cnt <= sv_cnt + 1;
            end
            if (m_dv) begin
                if (dv_first < 0) dv_first <= cyc - base;
                dv_lastc <= cyc - base;
            end
            if (m_dv && m_rdy) begin
                acc_cnt <= acc_cnt + 1;
                if (m_dl) begin
                    acc_last_cnt <= acc_last_cnt + 1;
                    acc_last_c   <= cyc - base;
                end
            end
            if (m_busy) busy_lastc <= cyc - base;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to #1 after the edge that starts relative cycle n.
    task automatic at_cycle(input int n);
        int guard = 0;
        while ((cyc - base) != n && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) chk("at_cycle_timeout", cyc - base, n);
    endtask

    task automatic set_last(input logic [15:0] v);
        case (sel)
            0:       if_any.last = v;
            1:       if_all.last = v[3:0];
            default: if_ovf.last = v;
        endcase
    endtask

    task automatic set_ready(input logic r);
        case (sel)
            0:       if_any.dst_ready = r;
            1:       if_all.dst_ready = r;
            default: if_ovf.dst_ready = r;
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_clr = 1'b0;
        base = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_any.last = '0; if_all.last = '0; if_ovf.last = '0;
        if_any.dst_ready = 1'b1; if_all.dst_ready = 1'b1; if_ovf.dst_ready = 1'b1;

        // Reset state and a single ANY-mode burst
        sel = 0;
        do_reset();
        chk("rst_dst_valid", if_any.dst_valid, 0);
        chk("rst_dst_last", if_any.dst_last, 0);
        chk("rst_stream_v", if_any.stream_v, 0);
        chk("rst_stream_i", if_any.stream_i, 0);
        chk("rst_busy", if_any.busy, 0);
        chk("rst_overflow", if_any.overflow, 0);
        at_cycle(10); set_last(16'h0004);
        at_cycle(11); set_last(16'h0000);
        at_cycle(40);
        chk("any_sv_first", sv_first, 14);
        chk("any_sv_last", sv_lastc, 21);
        chk("any_sv_cnt", sv_cnt, 8);
        for (int k = 0; k < 8; k++) chk($sformatf("any_idx%0d", k), int'(idx_log[k]), k);
        chk("any_dv_first", dv_first, 15);
        chk("any_dv_last", dv_lastc, 22);
        chk("any_tlast_cnt", acc_last_cnt, 1);
        chk("any_tlast_cycle", acc_last_c, 22);
        chk("any_busy_last", busy_lastc, 22);

        // Backpressure in cycles 16-18
        do_reset();
        at_cycle(10); set_last(16'h0004);
        at_cycle(11); set_last(16'h0000);
        at_cycle(16); set_ready(1'b0);
        at_cycle(17);
        chk("bp_frozen_idx", if_any.stream_i, 2);
        chk("bp_frozen_sv", if_any.stream_v, 0);
        chk("bp_held_valid", if_any.dst_valid, 1);
        at_cycle(19); set_ready(1'b1);
        at_cycle(45);
        chk("bp_sv_cnt", sv_cnt, 8);
        chk("bp_sv_last", sv_lastc, 24);
        for (int k = 0; k < 8; k++) chk($sformatf("bp_idx%0d", k), int'(idx_log[k]), k);
        chk("bp_accepted", acc_cnt, 8);
        chk("bp_tlast_cnt", acc_last_cnt, 1);
        chk("bp_tlast_cycle", acc_last_c, 25);

        // Three queued triggers, back-to-back bursts
        do_reset();
        at_cycle(10); set_last(16'h0004);
        at_cycle(13); set_last(16'h0000);
        at_cycle(60);
        chk("q_sv_first", sv_first, 14);
        chk("q_sv_last", sv_lastc, 37);
        chk("q_sv_cnt", sv_cnt, 24);
        chk("q_idx8", int'(idx_log[8]), 0);
        chk("q_idx23", int'(idx_log[23]), 7);
        chk("q_tlast_cnt", acc_last_cnt, 3);
        chk("q_busy_last", busy_lastc, 38);

        // ALL mode, 4 cores
        sel = 1;
        do_reset();
        at_cycle(5);  set_last(16'h0001);
        at_cycle(6);  set_last(16'h0000);
        at_cycle(7);  set_last(16'h0002);
        at_cycle(8);  set_last(16'h0002);
        at_cycle(9);  set_last(16'h000C);
        at_cycle(10); set_last(16'h0000);
        at_cycle(40);
        chk("all_sv_first", sv_first, 13);
        chk("all_sv_cnt", sv_cnt, 8);
        chk("all_tlast_cnt", acc_last_cnt, 1);
        chk("all_busy_last", busy_lastc, 21);
        at_cycle(41); set_last(16'h0001);
        at_cycle(42); set_last(16'h0000);
        at_cycle(70);
        chk("all_mask_cleared_sv", sv_cnt, 8);
        chk("all_mask_cleared_busy", busy_lastc, 21);

        // Overflow with a 2-deep queue
        sel = 2;
        set_ready(1'b0);
        do_reset();
        at_cycle(10); set_last(16'h0001);
        at_cycle(14);
        chk("ovf_before", if_ovf.overflow, 0);
        at_cycle(15); set_last(16'h0000);
        chk("ovf_after", if_ovf.overflow, 1);
        at_cycle(20); set_ready(1'b1);
        at_cycle(60);
        chk("ovf_sv_first", sv_first, 20);
        chk("ovf_sv_cnt", sv_cnt, 16);
        chk("ovf_tlast_cnt", acc_last_cnt, 2);
        chk("ovf_sticky", if_ovf.overflow, 1);
        chk("ovf_idle_busy", if_ovf.busy, 0);

        // Reset mid-burst at beat 3
        sel = 0;
        do_reset();
        at_cycle(10); set_last(16'h0004);
        at_cycle(11); set_last(16'h0000);
        at_cycle(17);
        chk("mid_idx_before", if_any.stream_i, 3);
        rst = 1'b1;
        at_cycle(18);
        rst = 1'b0;
        chk("mid_dst_valid", if_any.dst_valid, 0);
        chk("mid_dst_last", if_any.dst_last, 0);
        chk("mid_stream_v", if_any.stream_v, 0);
        chk("mid_stream_i", if_any.stream_i, 0);
        at_cycle(50);
        chk("mid_no_tlast", acc_last_cnt, 0);
        chk("mid_sv_last", sv_lastc, 17);
        chk("mid_sv_cnt", sv_cnt, 4);
        chk("mid_busy", if_any.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
